// File: rtl/dcm_rst_seq_pkg.sv
// ============================================================================
// Module   : dcm_rst_seq_pkg
// Purpose  : Shared state encoding and default timing constants for the
//            DCM reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcm_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET_DCM = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam int c_def_rst_cycles    = 8;
  localparam int c_def_lock_timeout  = 65535;
  localparam int c_def_max_retry     = 4;
  localparam int c_def_settle_cycles = 1024;
  localparam int c_retry_w           = 4;

  // Width of the shared state timer: must hold the largest of the timed limits.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// ============================================================================
// Module   : sync2
// Purpose  : Two-flop single-bit synchronizer, both flops reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dcm_rst_seq.sv
// ============================================================================
// Module   : dcm_rst_seq
// Purpose  : Pulses the DCM reset, waits for lock with bounded retries, lets
//            the lock settle, then releases the downstream system reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcm_rst_seq
  import dcm_rst_seq_pkg::*;
#(
  parameter int RST_CYCLES    = c_def_rst_cycles,
  parameter int LOCK_TIMEOUT  = c_def_lock_timeout,
  parameter int MAX_RETRY     = c_def_max_retry,
  parameter int SETTLE_CYCLES = c_def_settle_cycles
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic       dcm_lock_a,
  input  logic       restart,
  output logic       dcm_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  localparam int c_cnt_w = cnt_width(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);

  localparam logic [c_cnt_w-1:0]   c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0]   c_rst_last  = c_cnt_w'(RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]   c_lock_last = c_cnt_w'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that saw lock already counts as the first locked cycle.
  localparam logic [c_cnt_w-1:0]   c_settle_last = c_cnt_w'(SETTLE_CYCLES - 2);
  localparam logic [c_retry_w-1:0] c_retry_last  = c_retry_w'(MAX_RETRY - 1);
  localparam logic [c_retry_w-1:0] c_retry_max   = c_retry_w'(MAX_RETRY);

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_retry_w-1:0] r_retry;

  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [c_retry_w-1:0] w_retry_nxt;
  logic                 w_attempt_fail;
  logic                 w_lock_s;

  sync2 u_lock_sync (
    .clk (clk48),
    .rst (rst),
    .i_d (dcm_lock_a),
    .o_q (w_lock_s)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_retry_nxt    = r_retry;
    w_attempt_fail = 1'b0;

    case (r_state)
      ST_RESET_DCM: begin
        w_cnt_nxt = r_cnt + c_cnt_one;
        if (r_cnt == c_rst_last) w_state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        w_cnt_nxt = r_cnt + c_cnt_one;
        if (w_lock_s)                 w_state_nxt    = ST_SETTLE;
        else if (r_cnt == c_lock_last) w_attempt_fail = 1'b1;
      end
      ST_SETTLE: begin
        w_cnt_nxt = r_cnt + c_cnt_one;
        if (!w_lock_s) begin
          w_attempt_fail = 1'b1;
        end else if (r_cnt == c_settle_last) begin
          w_state_nxt = ST_RUN;
          w_retry_nxt = '0;
        end
      end
      ST_RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = ST_RESET_DCM;
          w_retry_nxt = '0;
        end
      end
      ST_FAIL: begin
        w_state_nxt = ST_FAIL;
      end
      default: begin
        w_state_nxt = ST_RESET_DCM;
        w_retry_nxt = '0;
      end
    endcase

    if (w_attempt_fail) begin
      if (r_retry == c_retry_last) begin
        w_state_nxt = ST_FAIL;
        w_retry_nxt = c_retry_max;
      end else begin
        w_state_nxt = ST_RESET_DCM;
        w_retry_nxt = r_retry + 4'd1;
      end
    end

    // A restart overrides every other event seen in the same cycle.
    if (restart) begin
      w_state_nxt = ST_RESET_DCM;
      w_retry_nxt = '0;
    end

    if ((w_state_nxt != r_state) || restart) w_cnt_nxt = '0;
  end

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      r_state <= ST_RESET_DCM;
      r_cnt   <= '0;
      r_retry <= '0;
      dcm_rst <= 1'b1;
      sys_rst <= 1'b1;
      ready   <= 1'b0;
      fail    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_retry <= w_retry_nxt;
      dcm_rst <= (w_state_nxt == ST_RESET_DCM);
      sys_rst <= (w_state_nxt != ST_RUN);
      ready   <= (w_state_nxt == ST_RUN);
      fail    <= (w_state_nxt == ST_FAIL);
    end
  end

  assign retry_cnt = r_retry;

endmodule

`default_nettype wire

// File: tb/tb_dcm_rst_seq.sv
// ============================================================================
// Module   : tb_dcm_rst_seq
// Purpose  : Cycle-accurate directed vector bench for dcm_rst_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcm_rst_seq;

  typedef struct packed {
    logic       lock;
    logic       restart;
    logic [7:0] exp;   // {dcm_rst, sys_rst, ready, fail, retry_cnt[3:0]}
  } vec_t;

  logic       clk48 = 1'b0;
  logic       rst;
  logic       dcm_lock_a;
  logic       restart;
  logic       dcm_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  always #5 clk48 = ~clk48;

  dcm_rst_seq #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (16),
    .MAX_RETRY    (3),
    .SETTLE_CYCLES(8)
  ) dut (
    .clk48     (clk48),
    .rst       (rst),
    .dcm_lock_a(dcm_lock_a),
    .restart   (restart),
    .dcm_rst   (dcm_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt)
  );

  function automatic logic [7:0] outs();
    return {dcm_rst, sys_rst, ready, fail, retry_cnt};
  endfunction

  function automatic logic [7:0] ev(input logic d, input logic s, input logic r,
                                    input logic f, input logic [3:0] rc);
    return {d, s, r, f, rc};
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {dcm,sys,rdy,fail,retry}=%b expected %b", name, got, exp);
    end
  endtask

  task automatic vn(input int n, input logic lk, input logic rs, input logic [7:0] exp);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.lock    = lk;
      v.restart = rs;
      v.exp     = exp;
      vecs.push_back(v);
    end
  endtask

  task automatic step();
    @(posedge clk48);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    dcm_lock_a = 1'b0;
    restart    = 1'b0;

    // Power-up lock sequence, with lock arriving 3 cycles after dcm_rst falls
    vn(3,  0, 0, ev(1, 1, 0, 0, 0));
    vn(4,  0, 0, ev(0, 1, 0, 0, 0));
    vn(9,  1, 0, ev(0, 1, 0, 0, 0));
    vn(2,  1, 0, ev(0, 0, 1, 0, 0));
    // Lock loss in RUN, re-pulse and relock
    vn(2,  0, 0, ev(0, 0, 1, 0, 0));
    vn(4,  0, 0, ev(1, 1, 0, 0, 0));
    vn(1,  0, 0, ev(0, 1, 0, 0, 0));
    vn(9,  1, 0, ev(0, 1, 0, 0, 0));
    vn(2,  1, 0, ev(0, 0, 1, 0, 0));
    // Restart from RUN, then a one-cycle lock glitch at settle count 6
    vn(1,  1, 1, ev(1, 1, 0, 0, 0));
    vn(3,  1, 0, ev(1, 1, 0, 0, 0));
    vn(6,  1, 0, ev(0, 1, 0, 0, 0));
    vn(1,  0, 0, ev(0, 1, 0, 0, 0));
    vn(1,  1, 0, ev(0, 1, 0, 0, 0));
    vn(1,  1, 0, ev(1, 1, 0, 0, 1));
    vn(3,  1, 0, ev(1, 1, 0, 0, 1));
    vn(8,  1, 0, ev(0, 1, 0, 0, 1));
    vn(1,  1, 0, ev(0, 0, 1, 0, 0));
    // Lock lost for good: three pulses, two retries, then FAIL
    vn(2,  0, 0, ev(0, 0, 1, 0, 0));
    vn(4,  0, 0, ev(1, 1, 0, 0, 0));
    vn(16, 0, 0, ev(0, 1, 0, 0, 0));
    vn(4,  0, 0, ev(1, 1, 0, 0, 1));
    vn(16, 0, 0, ev(0, 1, 0, 0, 1));
    vn(4,  0, 0, ev(1, 1, 0, 0, 2));
    vn(16, 0, 0, ev(0, 1, 0, 0, 2));
    vn(10, 0, 0, ev(0, 1, 0, 1, 3));
    // Restart out of FAIL coincident with lock rising
    vn(1,  1, 1, ev(1, 1, 0, 0, 0));
    vn(3,  1, 0, ev(1, 1, 0, 0, 0));
    vn(8,  1, 0, ev(0, 1, 0, 0, 0));
    vn(2,  1, 0, ev(0, 0, 1, 0, 0));

    step();
    step();
    chk("reset_state", outs(), ev(1, 1, 0, 0, 0));
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      dcm_lock_a = vecs[i].lock;
      restart    = vecs[i].restart;
      step();
      chk($sformatf("vec[%0d]", i), outs(), vecs[i].exp);
    end
    restart = 1'b0;

    // Async reset midway through SETTLE, then a full re-sequence
    restart = 1'b1;
    step();
    restart = 1'b0;
    for (int k = 0; k < 8; k++) step();
    chk("settle_before_rst", outs(), ev(0, 1, 0, 0, 0));
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", outs(), ev(1, 1, 0, 0, 0));
    step();
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("post_rst_cycle%0d", k), outs(),
          ev(k <= 3, k != 12, k == 12, 0, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
